// File: rtl/cpu_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: ALU ops, FSM states, fault codes, opcodes.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'd0,
        FLT_ILLEGAL = 2'd1,
        FLT_ZERO    = 2'd2,
        FLT_TIMEOUT = 2'd3
    } fault_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 selects the base operation for both R- and I-type; SUB is the only funct7 variant.
    function automatic alu_op_t f3_to_op(input logic [2:0] f3);
        alu_op_t op;
        case (f3)
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_decoder.sv
// Classifies an RV32I instruction word into ALU op, immediate select and legality.
// Latency: purely combinational.
// Backpressure: none.
module seq_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_op_t     alu_op,
    output logic        alu_src_imm,
    output logic        legal,
    output logic        is_zero
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign is_zero = (instr == 32'd0);

    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        legal       = 1'b0;
        if (opcode == OP_R) begin
            // SLTU (funct3 011) and any funct7 other than the SUB encoding are rejected.
            if (funct7 == F7_ZERO && funct3 != 3'b011) begin
                legal  = 1'b1;
                alu_op = f3_to_op(funct3);
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                legal  = 1'b1;
                alu_op = ALU_SUB;
            end
        end else if (opcode == OP_I) begin
            alu_src_imm = 1'b1;
            alu_op      = f3_to_op(funct3);
            // Shift immediates carry funct7 in imm[11:5]; only the logical form is supported.
            case (funct3)
                3'b011:         legal = 1'b0;
                3'b001, 3'b101: legal = (funct7 == F7_ZERO);
                default:        legal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control FSM with imem req/ack; optional SEQ_INSTRET_EN counters.
// Latency: 3 + EXEC_CYCLES cycles per instruction with zero-wait imem; all outputs registered.
// Backpressure: FETCH holds imem_req until imem_ack or IMEM_TIMEOUT cycles, then halts with a fault.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 16,
    parameter int EXEC_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir_out,
    output logic        pc_en,
    output logic        rf_we,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  fault
`ifdef SEQ_INSTRET_EN
    ,
    output logic [63:0] instret,
    output logic [63:0] cycle_cnt
`endif
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(IMEM_TIMEOUT - 1);
    localparam logic [3:0] EXEC_LOAD    = 4'(EXEC_CYCLES - 1);

    seq_state_t  state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [3:0]  exec_cnt_q, exec_cnt_d;
    logic [31:0] ir_q, ir_d;
    alu_op_t     alu_op_q, alu_op_d;
    logic        alu_src_imm_q, alu_src_imm_d;
    fault_t      fault_q, fault_d;
    logic        imem_req_q, imem_req_d;
    logic        wb_en_q, wb_en_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;

    alu_op_t     dec_op;
    logic        dec_imm;
    logic        dec_legal;
    logic        dec_zero;

    seq_decoder u_dec (
        .instr       (ir_q),
        .alu_op      (dec_op),
        .alu_src_imm (dec_imm),
        .legal       (dec_legal),
        .is_zero     (dec_zero)
    );

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        exec_cnt_d    = exec_cnt_q;
        ir_d          = ir_q;
        alu_op_d      = alu_op_q;
        alu_src_imm_d = alu_src_imm_q;
        fault_d       = fault_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                // An ack on the final allowed cycle wins over the timeout.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    timer_d = 8'd0;
                    state_d = S_DECODE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    fault_d = FLT_TIMEOUT;
                    timer_d = 8'd0;
                    state_d = S_HALT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (dec_zero) begin
                    fault_d = FLT_ZERO;
                    state_d = S_HALT;
                end else if (!dec_legal) begin
                    fault_d = FLT_ILLEGAL;
                    state_d = S_HALT;
                end else begin
                    alu_op_d      = dec_op;
                    alu_src_imm_d = dec_imm;
                    exec_cnt_d    = EXEC_LOAD;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_cnt_q == 4'd0) state_d = S_WB;
                else                    exec_cnt_d = exec_cnt_q - 4'd1;
            end
            S_WB: begin
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered so enables cannot glitch.
        imem_req_d = (state_d == S_FETCH);
        wb_en_d    = (state_d == S_WB);
        halted_d   = (state_d == S_HALT);
        busy_d     = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            timer_q       <= 8'd0;
            exec_cnt_q    <= 4'd0;
            ir_q          <= 32'd0;
            alu_op_q      <= ALU_ADD;
            alu_src_imm_q <= 1'b0;
            fault_q       <= FLT_NONE;
            imem_req_q    <= 1'b0;
            wb_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            exec_cnt_q    <= exec_cnt_d;
            ir_q          <= ir_d;
            alu_op_q      <= alu_op_d;
            alu_src_imm_q <= alu_src_imm_d;
            fault_q       <= fault_d;
            imem_req_q    <= imem_req_d;
            wb_en_q       <= wb_en_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign ir_out      = ir_q;
    assign pc_en       = wb_en_q;
    assign rf_we       = wb_en_q;
    assign alu_op      = alu_op_q;
    assign alu_src_imm = alu_src_imm_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

`ifdef SEQ_INSTRET_EN
    logic [63:0] instret_q, instret_d;
    logic [63:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        instret_d   = instret_q + {63'd0, wb_en_q};
        cycle_cnt_d = cycle_cnt_q + {63'd0, busy_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_q   <= 64'd0;
            cycle_cnt_q <= 64'd0;
        end else begin
            instret_q   <= instret_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign instret   = instret_q;
    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule
